// File: rtl/iq_demod_integrator_mc.sv
// rtl/iq_demod_integrator_mc.sv - multi-channel I/Q demodulating window integrator
module iq_demod_integrator_mc #(
  parameter int NUM_CH    = 4,
  parameter int NUM_LANES = 5,
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 32,
  parameter int LEN_W     = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cfg_wr_en,
  input  logic [1:0]                        cfg_addr,
  input  logic [31:0]                       cfg_wr_data,
  input  logic                              trigger,
  input  logic                              in_valid,
  input  logic [NUM_CH*NUM_LANES*DATA_W-1:0] adc_data,
  input  logic [NUM_LANES*DATA_W-1:0]       sin_lanes,
  input  logic [NUM_LANES*DATA_W-1:0]       cos_lanes,
  output logic                              busy,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_CH*ACC_W-1:0]           i_out,
  output logic [NUM_CH*ACC_W-1:0]           q_out,
  output logic                              overflow,
  output logic                              trig_missed
);
  localparam int PROD_W = 2 * DATA_W;
  // Lane sums plus accumulator fit here without wrapping, so saturation is exact.
  localparam int SUM_W  = PROD_W + $clog2(NUM_LANES) + 1;
  localparam int WIDE_W = ACC_W + SUM_W;
  localparam logic signed [WIDE_W-1:0] ACC_MAX   = {{(SUM_W + 1){1'b0}}, {(ACC_W - 1){1'b1}}};
  localparam logic signed [WIDE_W-1:0] ACC_MIN   = {{(SUM_W + 1){1'b1}}, {(ACC_W - 1){1'b0}}};
  localparam logic signed [ACC_W-1:0]  ACC_MAX_N = {1'b0, {(ACC_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  ACC_MIN_N = {1'b1, {(ACC_W - 1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DELAY, INTEG, DRAIN} stateT;

  stateT             state, nextState;
  logic [LEN_W-1:0]  cnt, nextCnt;
  logic              latchCfg, loadOut;

  logic [LEN_W-1:0]  intLenReg, delayReg;
  logic [NUM_CH-1:0] chEnReg;
  logic [4:0]        shiftReg;
  logic [LEN_W-1:0]  intLenSh, delaySh;
  logic [NUM_CH-1:0] chEnSh;
  logic [4:0]        shiftSh;
  logic [LEN_W-1:0]  lenLast, delayLast;
  logic              clrSticky, dropRes, satHit, unusedCfgBits;

  logic signed [PROD_W-1:0] pI [NUM_CH][NUM_LANES];
  logic signed [PROD_W-1:0] pQ [NUM_CH][NUM_LANES];
  logic                     tagValid;
  logic signed [WIDE_W-1:0] sumI [NUM_CH];
  logic signed [WIDE_W-1:0] sumQ [NUM_CH];
  logic signed [WIDE_W-1:0] wideI [NUM_CH];
  logic signed [WIDE_W-1:0] wideQ [NUM_CH];
  logic signed [ACC_W-1:0]  accI [NUM_CH];
  logic signed [ACC_W-1:0]  accQ [NUM_CH];
  logic signed [ACC_W-1:0]  nextI [NUM_CH];
  logic signed [ACC_W-1:0]  nextQ [NUM_CH];

  function automatic logic signed [ACC_W-1:0] satAcc(input logic signed [WIDE_W-1:0] v);
    if (v > ACC_MAX)      return ACC_MAX_N;
    else if (v < ACC_MIN) return ACC_MIN_N;
    else                  return v[ACC_W-1:0];
  endfunction

  assign clrSticky     = cfg_wr_en && (cfg_addr == 2'd3) && cfg_wr_data[0];
  assign unusedCfgBits = ^cfg_wr_data;
  // A zero window length still integrates one valid cycle.
  assign lenLast       = (intLenSh == '0) ? '0 : intLenSh - LEN_W'(1);
  assign delayLast     = delaySh - LEN_W'(1);
  assign busy          = (state != IDLE);
  assign dropRes       = loadOut && out_valid && !out_ready;

  // Live configuration registers, written at any time.
  always_ff @(posedge clk) begin
    if (rst) begin
      intLenReg <= LEN_W'(1);
      delayReg  <= '0;
      chEnReg   <= '1;
      shiftReg  <= '0;
    end else if (cfg_wr_en) begin
      case (cfg_addr)
        2'd0: intLenReg <= cfg_wr_data[LEN_W-1:0];
        2'd1: delayReg  <= cfg_wr_data[LEN_W-1:0];
        2'd2: chEnReg   <= cfg_wr_data[NUM_CH-1:0];
        2'd3: shiftReg  <= cfg_wr_data[12:8];
        default: ;
      endcase
    end
  end

  // Shadow copies frozen for the duration of an accepted window.
  always_ff @(posedge clk) begin
    if (rst) begin
      intLenSh <= LEN_W'(1);
      delaySh  <= '0;
      chEnSh   <= '1;
      shiftSh  <= '0;
    end else if (latchCfg) begin
      intLenSh <= intLenReg;
      delaySh  <= delayReg;
      chEnSh   <= chEnReg;
      shiftSh  <= shiftReg;
    end
  end

  // Window sequencer state and shared delay/length/drain counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  // Window sequencer transitions; delay and length only advance on valid cycles.
  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    latchCfg  = 1'b0;
    loadOut   = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) begin
          latchCfg  = 1'b1;
          nextCnt   = '0;
          nextState = (delayReg != '0) ? DELAY : INTEG;
        end
      end
      DELAY: begin
        if (in_valid) begin
          if (cnt == delayLast) begin
            nextCnt   = '0;
            nextState = INTEG;
          end else begin
            nextCnt = cnt + LEN_W'(1);
          end
        end
      end
      INTEG: begin
        if (in_valid) begin
          if (cnt == lenLast) begin
            nextCnt   = '0;
            nextState = DRAIN;
          end else begin
            nextCnt = cnt + LEN_W'(1);
          end
        end
      end
      DRAIN: begin
        if (cnt == LEN_W'(1)) begin
          loadOut   = 1'b1;
          nextCnt   = '0;
          nextState = IDLE;
        end else begin
          nextCnt = cnt + LEN_W'(1);
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Stage 1: per-lane products, tagged with whether the cycle is integrated.
  always_ff @(posedge clk) begin
    if (rst) begin
      tagValid <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        for (int k = 0; k < NUM_LANES; k++) begin
          pI[c][k] <= '0;
          pQ[c][k] <= '0;
        end
      end
    end else begin
      tagValid <= in_valid && (state == INTEG);
      for (int c = 0; c < NUM_CH; c++) begin
        for (int k = 0; k < NUM_LANES; k++) begin
          pI[c][k] <= PROD_W'($signed(adc_data[(c*NUM_LANES+k)*DATA_W +: DATA_W]))
                    * PROD_W'($signed(cos_lanes[k*DATA_W +: DATA_W]));
          pQ[c][k] <= PROD_W'($signed(adc_data[(c*NUM_LANES+k)*DATA_W +: DATA_W]))
                    * PROD_W'($signed(sin_lanes[k*DATA_W +: DATA_W]));
        end
      end
    end
  end

  // Stage 2 combinational part: lane sums, wide add and saturation.
  always_comb begin
    satHit = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      sumI[c] = '0;
      sumQ[c] = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
        sumI[c] = sumI[c] + WIDE_W'(pI[c][k]);
        sumQ[c] = sumQ[c] + WIDE_W'(pQ[c][k]);
      end
      wideI[c] = WIDE_W'(accI[c]) + sumI[c];
      wideQ[c] = WIDE_W'(accQ[c]) + sumQ[c];
      nextI[c] = satAcc(wideI[c]);
      nextQ[c] = satAcc(wideQ[c]);
      if (tagValid && chEnSh[c] &&
          (wideI[c] > ACC_MAX || wideI[c] < ACC_MIN ||
           wideQ[c] > ACC_MAX || wideQ[c] < ACC_MIN))
        satHit = 1'b1;
    end
  end

  // Stage 2 accumulators; disabled channels are pinned at zero.
  always_ff @(posedge clk) begin
    if (rst || latchCfg) begin
      for (int c = 0; c < NUM_CH; c++) begin
        accI[c] <= '0;
        accQ[c] <= '0;
      end
    end else if (tagValid) begin
      for (int c = 0; c < NUM_CH; c++) begin
        accI[c] <= chEnSh[c] ? nextI[c] : '0;
        accQ[c] <= chEnSh[c] ? nextQ[c] : '0;
      end
    end
  end

  // Result register with hold-under-backpressure; a result arriving while blocked is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      i_out     <= '0;
      q_out     <= '0;
    end else if (loadOut && (!out_valid || out_ready)) begin
      out_valid <= 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        i_out[c*ACC_W +: ACC_W] <= accI[c] >>> shiftSh;
        q_out[c*ACC_W +: ACC_W] <= accQ[c] >>> shiftSh;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky status flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow    <= 1'b0;
      trig_missed <= 1'b0;
    end else begin
      if (dropRes || satHit) overflow <= 1'b1;
      else if (clrSticky)    overflow <= 1'b0;
      if (trigger && busy)   trig_missed <= 1'b1;
      else if (clrSticky)    trig_missed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_iq_demod_integrator_mc.sv
// tb/tb_iq_demod_integrator_mc.sv - scoreboard bench for iq_demod_integrator_mc
module tb_iq_demod_integrator_mc;
  localparam int NUM_CH = 4, NUM_LANES = 5, DATA_W = 16, ACC_W = 32, LEN_W = 16;
  localparam int CW = NUM_CH * ACC_W;
  localparam longint MAXA = 64'sd2147483647;
  localparam longint MINA = -64'sd2147483648;

  logic clk, rst, cfg_wr_en, trigger, in_valid, out_ready;
  logic [1:0] cfg_addr;
  logic [31:0] cfg_wr_data;
  logic [NUM_CH*NUM_LANES*DATA_W-1:0] adc_data;
  logic [NUM_LANES*DATA_W-1:0] sin_lanes, cos_lanes;
  logic busy, out_valid, overflow, trig_missed;
  logic [CW-1:0] i_out, q_out;

  iq_demod_integrator_mc #(.NUM_CH(NUM_CH), .NUM_LANES(NUM_LANES), .DATA_W(DATA_W),
                           .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr),
    .cfg_wr_data(cfg_wr_data), .trigger(trigger), .in_valid(in_valid),
    .adc_data(adc_data), .sin_lanes(sin_lanes), .cos_lanes(cos_lanes),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .i_out(i_out), .q_out(q_out), .overflow(overflow), .trig_missed(trig_missed));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [CW-1:0] i; logic [CW-1:0] q; } resT;
  resT    sbQ[$];
  longint latQ[$];
  longint cyc = 0;
  int checks = 0, failures = 0;
  bit prevOv = 1'b0;

  logic signed [DATA_W-1:0] adcV [NUM_CH][NUM_LANES];
  logic signed [DATA_W-1:0] cosV [NUM_LANES];
  logic signed [DATA_W-1:0] sinV [NUM_LANES];
  logic signed [DATA_W-1:0] adcBase [NUM_CH][NUM_LANES];
  logic signed [DATA_W-1:0] cosBase [NUM_LANES];
  logic signed [DATA_W-1:0] sinBase [NUM_LANES];

  int mIntLen, mDelay, mShift;
  logic [NUM_CH-1:0] mChEn;
  bit mOvf;

  always_comb begin
    adc_data = '0;
    sin_lanes = '0;
    cos_lanes = '0;
    for (int c = 0; c < NUM_CH; c++)
      for (int k = 0; k < NUM_LANES; k++)
        adc_data[(c*NUM_LANES+k)*DATA_W +: DATA_W] = adcV[c][k];
    for (int k = 0; k < NUM_LANES; k++) begin
      sin_lanes[k*DATA_W +: DATA_W] = sinV[k];
      cos_lanes[k*DATA_W +: DATA_W] = cosV[k];
    end
  end

  task automatic checkEq(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer: latency on each fresh result, data on each accepted result.
  always @(negedge clk) begin
    if (rst) begin
      prevOv = 1'b0;
    end else begin
      if (out_valid && !prevOv && latQ.size() > 0) begin
        checkEq("latency", CW'(cyc), CW'(latQ.pop_front()));
        checkEq("busy_at_valid", CW'(busy), '0);
      end
      if (out_valid && out_ready) begin
        checkEq("sb_has_entry", CW'(sbQ.size() == 0), '0);
        if (sbQ.size() > 0) begin
          resT r;
          r = sbQ.pop_front();
          for (int c = 0; c < NUM_CH; c++) begin
            checkEq($sformatf("i_ch%0d", c), CW'(i_out[c*ACC_W +: ACC_W]), CW'(r.i[c*ACC_W +: ACC_W]));
            checkEq($sformatf("q_ch%0d", c), CW'(q_out[c*ACC_W +: ACC_W]), CW'(r.q[c*ACC_W +: ACC_W]));
          end
        end
      end
      prevOv = out_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfgWrite(input logic [1:0] addr, input logic [31:0] data);
    cfg_wr_en = 1'b1; cfg_addr = addr; cfg_wr_data = data;
    tick(1);
    cfg_wr_en = 1'b0;
    case (addr)
      2'd0: mIntLen = int'(data[LEN_W-1:0]);
      2'd1: mDelay  = int'(data[LEN_W-1:0]);
      2'd2: mChEn   = data[NUM_CH-1:0];
      default: mShift = int'(data[12:8]);
    endcase
  endtask

  task automatic baseSet(input int a, input int co, input int s, input int vary);
    for (int c = 0; c < NUM_CH; c++)
      for (int k = 0; k < NUM_LANES; k++)
        adcBase[c][k] = DATA_W'(a + vary * (c * 7 + k));
    for (int k = 0; k < NUM_LANES; k++) begin
      cosBase[k] = DATA_W'(co + vary * k);
      sinBase[k] = DATA_W'(s - vary * k);
    end
  endtask

  // mode 0: base values, 1: bounded random, 2: full-range garbage
  task automatic setData(input int mode);
    for (int c = 0; c < NUM_CH; c++)
      for (int k = 0; k < NUM_LANES; k++)
        adcV[c][k] = (mode == 0) ? adcBase[c][k] :
                     (mode == 1) ? DATA_W'(int'($urandom_range(0, 8191)) - 4096) : DATA_W'($urandom);
    for (int k = 0; k < NUM_LANES; k++) begin
      cosV[k] = (mode == 0) ? cosBase[k] :
                (mode == 1) ? DATA_W'(int'($urandom_range(0, 8191)) - 4096) : DATA_W'($urandom);
      sinV[k] = (mode == 0) ? sinBase[k] :
                (mode == 1) ? DATA_W'(int'($urandom_range(0, 8191)) - 4096) : DATA_W'($urandom);
    end
  endtask

  task automatic runWindow(input bit randData, input bit gapped, input bit pushRes,
                           input bit chkLat, input bit midTrig);
    longint accI [NUM_CH];
    longint accQ [NUM_CH];
    longint sI, sQ, lastCyc;
    int skip, need, n, sShift, g;
    logic [NUM_CH-1:0] sChEn;
    bit v;
    resT r;
    sChEn = mChEn; sShift = mShift; skip = mDelay;
    need = (mIntLen == 0) ? 1 : mIntLen;
    lastCyc = 0;
    for (int c = 0; c < NUM_CH; c++) begin accI[c] = 0; accQ[c] = 0; end
    trigger = 1'b1; in_valid = 1'b1; setData(2);
    tick(1);
    trigger = 1'b0; n = 0;
    while (need > 0 && n < 4000) begin
      v = gapped ? (n % 2 == 0) : 1'b1;
      in_valid = v;
      trigger = midTrig && (n == 1);
      setData(!v ? 2 : (randData ? 1 : 0));
      if (v) begin
        if (skip > 0) skip--;
        else begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (sChEn[c]) begin
              sI = 0; sQ = 0;
              for (int k = 0; k < NUM_LANES; k++) begin
                sI += longint'(adcV[c][k]) * longint'(cosV[k]);
                sQ += longint'(adcV[c][k]) * longint'(sinV[k]);
              end
              accI[c] += sI; accQ[c] += sQ;
              if (accI[c] > MAXA) begin accI[c] = MAXA; mOvf = 1'b1; end
              if (accI[c] < MINA) begin accI[c] = MINA; mOvf = 1'b1; end
              if (accQ[c] > MAXA) begin accQ[c] = MAXA; mOvf = 1'b1; end
              if (accQ[c] < MINA) begin accQ[c] = MINA; mOvf = 1'b1; end
            end
          end
          need--;
          lastCyc = cyc;
        end
      end
      n++;
      tick(1);
    end
    trigger = 1'b0; in_valid = 1'b0;
    checkEq("window_done", CW'(need), '0);
    for (int c = 0; c < NUM_CH; c++) begin
      r.i[c*ACC_W +: ACC_W] = ACC_W'(accI[c] >>> sShift);
      r.q[c*ACC_W +: ACC_W] = ACC_W'(accQ[c] >>> sShift);
    end
    if (pushRes) sbQ.push_back(r);
    if (chkLat) latQ.push_back(lastCyc + 3);
    g = 0;
    while (busy && g < 20) begin tick(1); g++; end
    checkEq("busy_drop", CW'(busy), '0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkEq({tag, "_busy"}, CW'(busy), '0);
    checkEq({tag, "_out_valid"}, CW'(out_valid), '0);
    checkEq({tag, "_i_out"}, i_out, '0);
    checkEq({tag, "_q_out"}, q_out, '0);
    checkEq({tag, "_overflow"}, CW'(overflow), '0);
    checkEq({tag, "_trig_missed"}, CW'(trig_missed), '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cfg_wr_en = 1'b0; cfg_addr = '0; cfg_wr_data = '0;
    trigger = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    mIntLen = 1; mDelay = 0; mShift = 0; mChEn = '1; mOvf = 1'b0;
    baseSet(0, 0, 0, 0); setData(0);
    tick(3);
    checkResetOutputs("reset");
    rst = 1'b0;
    tick(1);

    // DC window
    cfgWrite(0, 4); cfgWrite(1, 0); cfgWrite(2, 32'hF); cfgWrite(3, 0);
    baseSet(100, 1000, 0, 0);
    runWindow(0, 0, 1, 1, 0);
    tick(3);
    checkEq("dc_i_ch0_const", CW'(i_out[ACC_W-1:0]), CW'(2000000));
    checkEq("dc_no_ovf", CW'(overflow), CW'(mOvf));

    // Delay with gapped valid
    cfgWrite(0, 3); cfgWrite(1, 2);
    baseSet(1, 1, 0, 0);
    runWindow(0, 1, 1, 1, 0);
    tick(3);
    checkEq("gap_i_ch3_const", CW'(i_out[3*ACC_W +: ACC_W]), CW'(15));

    // Random signed data with arithmetic shift
    cfgWrite(0, 6); cfgWrite(1, 1); cfgWrite(3, 32'h0300);
    runWindow(1, 0, 1, 1, 0);
    tick(3);

    // Backpressure: second result dropped, first held
    cfgWrite(3, 0); cfgWrite(0, 2); cfgWrite(1, 0);
    baseSet(7, -3, 5, 1);
    out_ready = 1'b0;
    runWindow(0, 0, 1, 1, 0);
    baseSet(9, 4, -2, 1);
    runWindow(0, 0, 0, 0, 0);
    tick(2);
    checkEq("bp_ovf_set", CW'(overflow), CW'(1));
    checkEq("bp_out_valid", CW'(out_valid), CW'(1));
    checkEq("bp_held_i", i_out, sbQ[0].i);
    checkEq("bp_held_q", q_out, sbQ[0].q);
    cfgWrite(3, 1);
    checkEq("bp_ovf_clr", CW'(overflow), '0);
    out_ready = 1'b1;
    tick(3);

    // Saturation, then shift on a saturated single cycle
    mOvf = 1'b0;
    cfgWrite(0, 500);
    baseSet(32767, 32767, 0, 0);
    runWindow(0, 0, 1, 1, 0);
    tick(3);
    checkEq("sat_i_ch0", CW'(i_out[ACC_W-1:0]), CW'(32'h7FFF_FFFF));
    checkEq("sat_ovf", CW'(overflow), CW'(mOvf));
    cfgWrite(3, 32'h0401);
    checkEq("sat_ovf_clr", CW'(overflow), '0);
    mOvf = 1'b0;
    cfgWrite(0, 1);
    runWindow(0, 0, 1, 1, 0);
    tick(3);
    checkEq("shift_ovf", CW'(overflow), CW'(mOvf));
    cfgWrite(3, 1);
    mOvf = 1'b0;

    // Channel mask and missed trigger during INTEG
    cfgWrite(0, 4); cfgWrite(2, 32'h5);
    baseSet(-50, 200, -300, 1);
    runWindow(0, 0, 1, 1, 1);
    tick(3);
    checkEq("mask_ch1_zero", CW'(i_out[ACC_W +: ACC_W]), '0);
    checkEq("trig_missed_set", CW'(trig_missed), CW'(1));
    cfgWrite(3, 1);
    checkEq("trig_missed_clr", CW'(trig_missed), '0);

    // Reset mid-window restores defaults and discards the partial window
    cfgWrite(0, 7); cfgWrite(1, 1); cfgWrite(2, 32'h3); cfgWrite(3, 32'h0200);
    trigger = 1'b1; in_valid = 1'b1; setData(2);
    tick(1);
    trigger = 1'b0;
    setData(0);
    tick(4);
    checkEq("pre_rst_busy", CW'(busy), CW'(1));
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkResetOutputs("midrst");
    mIntLen = 1; mDelay = 0; mChEn = '1; mShift = 0; mOvf = 1'b0;
    baseSet(11, -13, 17, 1);
    runWindow(0, 0, 1, 1, 0);
    tick(3);

    // Zero window length behaves as one
    cfgWrite(0, 0);
    baseSet(-3, 21, 8, 1);
    runWindow(0, 1, 1, 1, 0);
    tick(4);

    checkEq("sb_drained", CW'(sbQ.size()), '0);
    checkEq("lat_drained", CW'(latQ.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
